// File: rtl/sub_share_arb.sv
// Round-robin arbiter that time-shares one external combinational subtractor among N_REQ requesters.
// Optional build macro: SUB_ARB_SAT_EN (saturate rsp_diff to zero whenever a borrow occurs).
module sub_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       sub_a,
  output logic [WIDTH-1:0]       sub_b,
  input  logic [WIDTH-1:0]       sub_diff,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_diff,
  output logic                   rsp_borrow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   ptr_nxt_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             grant_vld_s;
  logic [WIDTH-1:0] grant_a_s;
  logic [WIDTH-1:0] grant_b_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;

  // Grant search: pass 0 covers indices below rr_ptr, pass 1 those at/above it; the last hit wins,
  // so the result is the first valid requester found searching upward from rr_ptr with wrap.
  always_comb begin : grant_search
    logic hit;
    hit         = 1'b0;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    grant_a_s   = '0;
    grant_b_s   = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        hit = req_valid[i] && ((p == 0) ? (IDW'(i) < rr_ptr_r) : (IDW'(i) >= rr_ptr_r));
        grant_vld_s = grant_vld_s | hit;
        grant_idx_s = hit ? IDW'(i) : grant_idx_s;
        grant_a_s   = hit ? req_a[i*WIDTH +: WIDTH] : grant_a_s;
        grant_b_s   = hit ? req_b[i*WIDTH +: WIDTH] : grant_b_s;
      end
    end
  end

  // Pointer advance, one-hot accept and result formatting
  always_comb begin
    ptr_nxt_s = (grant_idx_s == IDW'(N_REQ - 1)) ? '0 : grant_idx_s + 1'b1;
    req_ready = '0;
    if ((state_r == IDLE) && grant_vld_s) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = '0;
    end
    borrow_s = (sub_a < sub_b);
`ifdef SUB_ARB_SAT_EN
    diff_s = borrow_s ? '0 : sub_diff;
`else
    diff_s = sub_diff;
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pointer, subtractor operands and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      sub_a      <= '0;
      sub_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_diff   <= '0;
      rsp_borrow <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            sub_a    <= grant_a_s;
            sub_b    <= grant_b_s;
            rsp_id   <= grant_idx_s;
            rr_ptr_r <= ptr_nxt_s;
          end
        end
        ISSUE: begin
          rsp_diff   <= diff_s;
          rsp_borrow <= borrow_s;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_share_arb.sv
// Self-checking bench for sub_share_arb: scenario tasks plus a response scoreboard.
module tb_sub_share_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   sub_a;
  logic [W-1:0]   sub_b;
  logic [W-1:0]   sub_diff;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_diff;
  logic           rsp_borrow;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  always #5 clk = ~clk;

  // Stand-in for the shared subtractor living outside the arbiter
  assign sub_diff = sub_a - sub_b;

  sub_share_arb #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_diff(rsp_diff), .rsp_borrow(rsp_borrow)
  );

  function automatic logic [10:0] expect_rsp(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    logic       bw;
    d  = a - b;
    bw = (a < b);
`ifdef SUB_ARB_SAT_EN
    if (bw) d = 8'h00;
`endif
    return {id, d, bw};
  endfunction

  // Scoreboard: every accepted response must match the oldest pending expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d diff=%h borrow=%b, required no response", rsp_id, rsp_diff, rsp_borrow);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_id, rsp_diff, rsp_borrow} !== mon_exp) begin
          n_bad++;
          $display("FAIL rsp_data: got id=%0d diff=%h borrow=%b, required id=%0d diff=%h borrow=%b",
                   rsp_id, rsp_diff, rsp_borrow, mon_exp[10:9], mon_exp[8:1], mon_exp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0000; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, sub_a, sub_b} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_values: got %h, required 00000000",
               {req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, sub_a, sub_b});
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req_a[7:0] = 8'hCC; req_b[7:0] = 8'h33; req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b, required 0001", req_ready); end
    exp_q.push_back(expect_rsp(2'd0, 8'hCC, 8'h33));
    step(); req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got rsp_valid=%b, required 0", rsp_valid); end
    step();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_diff !== 8'h99) begin
      n_bad++; $display("FAIL basic_latency: got valid=%b diff=%h, required valid=1 diff=99", rsp_valid, rsp_diff);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got rsp_valid=%b, required 0", rsp_valid); end
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] want;
`ifdef SUB_ARB_SAT_EN
    want = 8'h00;
`else
    want = 8'hE9;
`endif
    req_a[23:16] = 8'h1C; req_b[23:16] = 8'h33; req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_grant: got %b, required 0100", req_ready); end
    exp_q.push_back(expect_rsp(2'd2, 8'h1C, 8'h33));
    step(); req_valid = 4'b0000;
    step();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_diff, rsp_borrow} !== {1'b1, 2'd2, want, 1'b1}) begin
      n_bad++; $display("FAIL wrap_rsp: got valid=%b id=%0d diff=%h borrow=%b, required valid=1 id=2 diff=%h borrow=1",
                        rsp_valid, rsp_id, rsp_diff, rsp_borrow, want);
    end
    step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; req_valid = 4'b0000;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = 8'hEC;
      req_b[k*W +: W] = 8'h37;
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== (4'b0001 << (g % 4))) begin
        n_bad++; $display("FAIL rr_grant: got %b at grant %0d, required requester %0d", req_ready, g, g % 4);
      end
      exp_q.push_back(expect_rsp(2'(g % 4), 8'hEC, 8'h37));
      step();
      if (g == 4) req_valid = 4'b0000;
      for (int s = 0; s < 2; s++) begin
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_spacing: got %b, required 0000", req_ready); end
        step();
      end
    end
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    req_a[15:8] = 8'h50; req_b[15:8] = 8'h10; req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b, required 0010", req_ready); end
    exp_q.push_back(expect_rsp(2'd1, 8'h50, 8'h10));
    step(); req_valid = 4'b0001;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_diff, req_ready} !== {1'b1, 2'd1, 8'h40, 4'b0000}) begin
        n_bad++; $display("FAIL bp_hold: got valid=%b id=%0d diff=%h ready=%b, required valid=1 id=1 diff=40 ready=0000",
                          rsp_valid, rsp_id, rsp_diff, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin
      n_bad++; $display("FAIL bp_release: got valid=%b ready=%b, required valid=0 ready=0001", rsp_valid, req_ready);
    end
    exp_q.push_back(expect_rsp(2'd0, 8'hEC, 8'h37));
    step(); req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    req_a[31:24] = 8'h10; req_b[31:24] = 8'h20; req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rstmid_grant: got %b, required 1000", req_ready); end
    step(); rst = 1'b1; req_valid = 4'b0000;
    step(); rst = 1'b0;
    req_a[7:0] = 8'h05; req_b[7:0] = 8'h07; req_valid = 4'b1001;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_diff, rsp_borrow, sub_a, sub_b} !== 28'h0) begin
      n_bad++; $display("FAIL rstmid_clear: got %h, required 0000000",
                        {rsp_valid, rsp_id, rsp_diff, rsp_borrow, sub_a, sub_b});
    end
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_regrant: got %b, required 0001", req_ready); end
    exp_q.push_back(expect_rsp(2'd0, 8'h05, 8'h07));
    step(); req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_idle();
    req_valid = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid} !== 5'b0) begin
        n_bad++; $display("FAIL idle_quiet: got ready=%b valid=%b, required ready=0000 valid=0", req_ready, rsp_valid);
      end
      step();
    end
    req_a[15:8] = 8'h00; req_b[15:8] = 8'hFF; req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL idle_ptr: got %b, required 0010", req_ready); end
    exp_q.push_back(expect_rsp(2'd1, 8'h00, 8'hFF));
    step(); req_valid = 4'b0000;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_idle();
    repeat (3) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
